// File: rtl/genius_pkg.sv
// Shared state encoding and default timing for the sequence playback controller.
package genius_pkg;

    localparam int unsigned TICK_DIV_DEFAULT  = 25000000;
    localparam int unsigned ON_TICKS_DEFAULT  = 2;
    localparam int unsigned GAP_TICKS_DEFAULT = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_e;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider: tick is high for one cycle out of every TICK_DIV,
// landing on the last cycle of each window counted from a clear.
module tick_prescaler
    import genius_pkg::*;
#(
    parameter int unsigned TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick = (cnt_q == LAST);

endmodule

// File: rtl/sequence_playback_ctrl.sv
// Plays steps 0..level: each step is shown for ON_TICKS ticks then blanked
// for GAP_TICKS ticks, with a one-cycle done pulse after the last step.
module sequence_playback_ctrl
    import genius_pkg::*;
#(
    parameter int unsigned TICK_DIV  = TICK_DIV_DEFAULT,
    parameter int unsigned ON_TICKS  = ON_TICKS_DEFAULT,
    parameter int unsigned GAP_TICKS = GAP_TICKS_DEFAULT
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] level,
    input  logic       abort,
    output logic [3:0] seq_idx,
    output logic       show_en,
    output logic       busy,
    output logic       done
);

    localparam int unsigned PH_MAX = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
    localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
    localparam logic [PH_W-1:0] ON_LAST  = PH_W'(ON_TICKS - 1);
    localparam logic [PH_W-1:0] GAP_LAST = PH_W'(GAP_TICKS - 1);

    state_e          state_q, state_d;
    logic [3:0]      level_q, level_d;
    logic [3:0]      seq_idx_q, seq_idx_d;
    logic [PH_W-1:0] phase_q, phase_d;
    logic            show_en_q, show_en_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic            tick;
    logic            ps_clear;

    // Holding the prescaler clear throughout IDLE aligns the first tick to SHOW entry.
    assign ps_clear = (state_q == IDLE);

    tick_prescaler #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_prescaler (
        .clock (clock),
        .reset (reset),
        .clear (ps_clear),
        .tick  (tick)
    );

    always_comb begin
        state_d   = state_q;
        level_d   = level_q;
        seq_idx_d = seq_idx_q;
        phase_d   = phase_q;
        show_en_d = show_en_q;
        busy_d    = busy_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d   = SHOW;
                    level_d   = level;
                    seq_idx_d = '0;
                    phase_d   = '0;
                    show_en_d = 1'b1;
                    busy_d    = 1'b1;
                end
            end
            SHOW: begin
                if (tick) begin
                    if (phase_q == ON_LAST) begin
                        state_d   = GAP;
                        phase_d   = '0;
                        show_en_d = 1'b0;
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end
            end
            GAP: begin
                if (tick) begin
                    if (phase_q == GAP_LAST) begin
                        phase_d = '0;
                        if (seq_idx_q == level_q) begin
                            state_d   = DONE;
                            seq_idx_d = '0;
                            done_d    = 1'b1;
                        end else begin
                            state_d   = SHOW;
                            seq_idx_d = seq_idx_q + 4'd1;
                            show_en_d = 1'b1;
                        end
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end
            end
            DONE: begin
                state_d   = IDLE;
                seq_idx_d = '0;
                busy_d    = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (abort && (state_q != IDLE)) begin
            state_d   = IDLE;
            seq_idx_d = '0;
            phase_d   = '0;
            show_en_d = 1'b0;
            busy_d    = 1'b0;
            done_d    = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= IDLE;
            level_q   <= '0;
            seq_idx_q <= '0;
            phase_q   <= '0;
            show_en_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            level_q   <= level_d;
            seq_idx_q <= seq_idx_d;
            phase_q   <= phase_d;
            show_en_q <= show_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign seq_idx = seq_idx_q;
    assign show_en = show_en_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_sequence_playback_ctrl.sv
// Directed bench for sequence_playback_ctrl with TICK_DIV=4, ON_TICKS=2, GAP_TICKS=1
// (12 cycles per step: 8 shown, 4 blank).
module tb_sequence_playback_ctrl;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [3:0] level;
    logic       abort;
    logic [3:0] seq_idx;
    logic       show_en;
    logic       busy;
    logic       done;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [3:0] lvl;
        int         done_cyc;
    } play_vec_t;

    play_vec_t vecs [4];

    sequence_playback_ctrl #(
        .TICK_DIV  (4),
        .ON_TICKS  (2),
        .GAP_TICKS (1)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .start   (start),
        .level   (level),
        .abort   (abort),
        .seq_idx (seq_idx),
        .show_en (show_en),
        .busy    (busy),
        .done    (done)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_all(input string name, input logic [3:0] e_idx, input logic e_show,
                           input logic e_busy, input logic e_done);
        chk({name, ".seq_idx"}, 32'(seq_idx), 32'(e_idx));
        chk({name, ".show_en"}, 32'(show_en), 32'(e_show));
        chk({name, ".busy"},    32'(busy),    32'(e_busy));
        chk({name, ".done"},    32'(done),    32'(e_done));
    endtask

    // Start is applied in "cycle 0"; after each step() we sit in the next cycle.
    task automatic run_play(input logic [3:0] lvl, input int done_cyc);
        logic [3:0] e_idx;
        logic       e_show, e_busy, e_done;
        int         max_idx;
        start = 1'b1;
        level = lvl;
        step();
        start = 1'b0;
        level = 4'd15 - lvl;
        max_idx = 0;
        for (int c = 1; c <= done_cyc + 1; c++) begin
            if (c < done_cyc) begin
                e_idx  = 4'((c - 1) / 12);
                e_show = (((c - 1) % 12) < 8);
                e_busy = 1'b1;
                e_done = 1'b0;
            end else if (c == done_cyc) begin
                e_idx = 4'd0; e_show = 1'b0; e_busy = 1'b1; e_done = 1'b1;
            end else begin
                e_idx = 4'd0; e_show = 1'b0; e_busy = 1'b0; e_done = 1'b0;
            end
            chk($sformatf("play_l%0d_c%0d", lvl, c), {seq_idx, show_en, busy, done},
                {e_idx, e_show, e_busy, e_done});
            if (int'(seq_idx) > max_idx) max_idx = int'(seq_idx);
            if (c <= done_cyc) step();
        end
        chk($sformatf("play_l%0d_max_idx", lvl), 32'(max_idx), 32'(lvl));
    endtask

    initial begin
        int done_cnt;

        vecs[0] = '{lvl: 4'd0,  done_cyc: 13};
        vecs[1] = '{lvl: 4'd2,  done_cyc: 37};
        vecs[2] = '{lvl: 4'd15, done_cyc: 193};
        vecs[3] = '{lvl: 4'd5,  done_cyc: 73};

        reset = 1'b0;
        start = 1'b1;
        abort = 1'b0;
        level = 4'd9;
        step();
        step();
        chk_all("reset_state", 4'd0, 1'b0, 1'b0, 1'b0);
        start = 1'b0;
        reset = 1'b1;
        step();

        for (int i = 0; i < 4; i++) begin
            run_play(vecs[i].lvl, vecs[i].done_cyc);
            step();
        end

        // start and abort together in IDLE: abort wins
        start = 1'b1; abort = 1'b1; level = 4'd3;
        step();
        start = 1'b0; abort = 1'b0;
        chk_all("start_abort_idle", 4'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk("start_abort_idle_later.busy", 32'(busy), 32'd0);

        // start with a new level mid-playback is ignored
        start = 1'b1; level = 4'd1;
        step();
        start = 1'b0;
        for (int c = 1; c < 10; c++) step();
        start = 1'b1; level = 4'd7;
        step();
        start = 1'b0;
        chk("restart_c11.busy", 32'(busy), 32'd1);
        for (int c = 11; c <= 26; c++) begin
            if (c == 13) chk("restart_c13.seq_idx", 32'(seq_idx), 32'd1);
            chk($sformatf("restart_c%0d.done", c), 32'(done), 32'(c == 25));
            chk($sformatf("restart_c%0d.busy", c), 32'(busy), 32'(c <= 25));
            step();
        end

        // abort during SHOW
        start = 1'b1; level = 4'd3;
        step();
        start = 1'b0;
        for (int c = 1; c < 5; c++) step();
        chk("abort_c5.show_en", 32'(show_en), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_all("abort_c6", 4'd0, 1'b0, 1'b0, 1'b0);
        done_cnt = 0;
        for (int c = 7; c < 70; c++) begin
            if (done || busy) done_cnt++;
            step();
        end
        chk("abort_no_done_after", 32'(done_cnt), 32'd0);

        // abort on the final GAP cycle must suppress done
        start = 1'b1; level = 4'd0;
        step();
        start = 1'b0;
        for (int c = 1; c < 12; c++) step();
        chk("abort_gap_c12.busy", 32'(busy), 32'd1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk_all("abort_gap_c13", 4'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk("abort_gap_c14.done", 32'(done), 32'd0);

        // reset mid-playback, then a fresh start
        start = 1'b1; level = 4'd3;
        step();
        start = 1'b0;
        for (int c = 1; c < 20; c++) step();
        chk("midreset_c20.seq_idx", 32'(seq_idx), 32'd1);
        reset = 1'b0;
        step();
        reset = 1'b1;
        chk_all("midreset_c21", 4'd0, 1'b0, 1'b0, 1'b0);
        step();
        chk("midreset_c22.done", 32'(done), 32'd0);
        start = 1'b1; level = 4'd3;
        step();
        start = 1'b0;
        chk_all("midreset_c23", 4'd0, 1'b1, 1'b1, 1'b0);
        done_cnt = 0;
        for (int c = 23; c <= 72; c++) begin
            if (c == 71) chk("midreset_c71.done", 32'(done), 32'd1);
            else if (done) done_cnt++;
            step();
        end
        chk("midreset_stray_done", 32'(done_cnt), 32'd0);
        chk("midreset_final.busy", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/sequence_playback_ctrl.md
SEQUENCE_PLAYBACK_CTRL -- requirements
Module: sequence_playback_ctrl

Interface
REQ-001 Parameter TICK_DIV, default 25000000: clock cycles per timing tick; SHALL be at least 1.
REQ-002 Parameter ON_TICKS, default 2: ticks each step is shown; SHALL be at least 1.
REQ-003 Parameter GAP_TICKS, default 1: blank ticks after each step; SHALL be at least 1.
REQ-004 clock  input  1  system clock; all logic SHALL be clocked on its rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 start  input  1  request to play steps 0..level; sampled every cycle.
REQ-007 level  input  4  index of the last step to play (0..15).
REQ-008 abort  input  1  cancels playback in progress.
REQ-009 seq_idx  output  4  index of the step currently being played.
REQ-010 show_en  output  1  high while the current step is displayed.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 done  output  1  one-cycle pulse on normal completion.

Function
REQ-013 The FSM SHALL have exactly four states: IDLE, SHOW, GAP and DONE.
REQ-014 In IDLE with start=1 and abort=0, the block SHALL latch level into level_q, clear seq_idx, clear the tick prescaler and phase counter, and enter SHOW next cycle.
REQ-015 If start and abort are high in the same IDLE cycle, abort SHALL win and the FSM SHALL stay in IDLE.
REQ-016 When start is accepted in cycle N, busy=1 and show_en=1 SHALL first appear in cycle N+1.
REQ-017 The prescaler SHALL emit a one-cycle tick every TICK_DIV cycles; the first tick falls TICK_DIV cycles after entering SHOW.
REQ-018 SHOW SHALL drive show_en=1 and last exactly ON_TICKS*TICK_DIV cycles, then go to GAP.
REQ-019 GAP SHALL drive show_en=0 and last exactly GAP_TICKS*TICK_DIV cycles; it SHALL then go to DONE if seq_idx==level_q, else increment seq_idx and go to SHOW.
REQ-020 seq_idx SHALL never exceed level_q; level=15 SHALL play 16 steps with no wrap to 0 mid-playback.
REQ-021 level=0 SHALL play exactly one step.
REQ-022 DONE SHALL last one cycle with done=1, busy=1 and seq_idx=0, then return to IDLE.
REQ-023 From a start accepted in cycle N, done SHALL pulse in cycle N+1+(level_q+1)*(ON_TICKS+GAP_TICKS)*TICK_DIV.
REQ-024 start while busy=1 SHALL be ignored, with no effect on state, counters or level_q.
REQ-025 Changes on level while busy=1 SHALL be ignored.
REQ-026 abort=1 in SHOW, GAP or DONE SHALL force IDLE next cycle with seq_idx=0 and show_en=0, and SHALL suppress done in that cycle.
REQ-027 All outputs SHALL be registered.

Reset
REQ-028 When reset=0 at a clock edge, the FSM SHALL go to IDLE, and seq_idx, show_en, busy, done, level_q, the prescaler and the phase counter SHALL all be 0.
REQ-029 Reset SHALL take priority over start and abort and SHALL take effect mid-playback with no done pulse.

Structure
REQ-030 The state encodings (IDLE=0, SHOW=1, GAP=2, DONE=3) and the default values of TICK_DIV, ON_TICKS and GAP_TICKS SHALL live in shared package genius_pkg.
REQ-031 The prescaler SHALL be a separate sub-module, tick_prescaler, with ports clock, reset, clear and tick, and a TICK_DIV parameter.

Verification (TICK_DIV=4, ON_TICKS=2, GAP_TICKS=1, start pulsed in cycle 0)
REQ-032 level=0 -> show_en high in cycles 1-8, low in 9-12, done in cycle 13, busy low from cycle 14.
REQ-033 level=2 -> seq_idx=0 in cycles 1-12, =1 in 13-24, =2 in 25-36; done in cycle 37.
REQ-034 level=15 -> 16 SHOW phases, seq_idx reaches 15 and never wraps, done in cycle 193.
REQ-035 level=1, then start=1 and level=7 in cycle 10 -> ignored; done still in cycle 25.
REQ-036 level=3 with abort in cycle 5 -> busy=0, show_en=0, seq_idx=0 in cycle 6, and no done pulse follows.
REQ-037 level=3 with reset=0 in cycle 20 -> all outputs 0 in cycle 21; a new start in cycle 22 begins playback from seq_idx=0.
